global_unpool_unit: RTL
=======================

Name: global_unpool_unit

Overview:
Inverse of the global average pooling stage. Accepts one 8-bit channel scalar per handshake and broadcasts it as a full IMG_W x IMG_H raster pixel stream, one pixel per accepted output beat. It sits downstream of pooled or attention scalars, where a feature plane must be reconstructed for element-wise ops.
- Holds one active scalar plus one pending scalar, so the next plane is accepted while the current plane streams.

Parameters:
IMG_W, 14, plane width in pixels
IMG_H, 14, plane height in pixels
TOTAL_PIXELS, IMG_W*IMG_H (localparam), beats per plane

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, synchronous, active-high
in_data  in  8  scalar to broadcast
in_valid  in  1  in_data valid
in_ready  out  1  block can accept a scalar
out_data  out  8  broadcast pixel
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts the beat
out_last  out  1  high on the final pixel of a plane, (IMG_W-1, IMG_H-1)

Behaviour:
- Reset values (rst sampled high at a posedge): out_valid=0, out_data=0, out_last=0, in_ready=1, x/y counters=0, pending empty, state IDLE.
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - out_data and out_last are held stable while out_valid && !out_ready.
- States:
  - IDLE: no active plane.
  - EMIT: streaming the active plane.
- in_ready = !pending_full. It is registered-state derived only and never combinational on out_ready.
- IDLE + input transfer:
  - Latch active<=in_data, x=y=0, go to EMIT.
  - out_valid=1 with out_data=in_data on the next cycle. Latency is 1 cycle.
- EMIT: on each output transfer, x increments. When x reaches IMG_W-1, x wraps to 0 and y increments.
- out_last = (x==IMG_W-1 && y==IMG_H-1), registered in step with out_data.
- Last-beat transfer with pending full:
  - active<=pending, pending empties, x=y=0, stay in EMIT.
  - out_valid stays 1, so there is no bubble between planes.
- Last-beat transfer with pending empty: go to IDLE, out_valid=0 next cycle.
- Input transfer in EMIT (pending empty, not last beat): scalar goes to pending, in_ready drops next cycle.
- Simultaneous input transfer and last-beat transfer with pending empty: bypass, active<=in_data directly. Pending stays empty, no bubble.
- Simultaneous input transfer and last-beat transfer with pending full: this is impossible, because in_ready=0.
- Counters: x is $clog2(IMG_W) bits and y is $clog2(IMG_H) bits. Neither ever exceeds its max. There is no overflow path.
- Reset mid-plane: the in-flight plane and pending scalar are discarded. All outputs return to reset values on the next cycle.
- in_valid while in_ready=0 is ignored. The source must hold the scalar.

Optional Feature:
Macro GLOBAL_UNPOOL_COORD_EN.
- Defined: adds output ports out_x ($clog2(IMG_W)) and out_y ($clog2(IMG_H)). They carry the raster coordinate of the current beat, are registered alongside out_data, reset to 0, and are held under backpressure.
- Undefined: these ports and their logic are absent. Counters remain internal only.

Decomposition:
- Shared package: IMG_W/IMG_H defaults, TOTAL_PIXELS, pixel width constant (8), state enum {IDLE, EMIT}.
- One natural sub-module: raster_xy_counter (x/y wrap counter with advance input, last flag, clear).
- Top holds the handshake, active/pending registers and FSM.

Test Plan:
1. Single scalar 100, out_ready=1 constantly -> 196 beats of 100. out_last only on beat 196. out_valid drops the cycle after, state IDLE.
2. Scalar 255 with out_ready toggling 1,0,1,0 -> exactly 196 transfers of 255. Data/last held while stalled. Plane takes 392 cycles.
3. Back-to-back scalars 100 then 200, second sent during beat 10 -> in_ready=0 after second accept. 196x100 then 196x200 with no out_valid gap. in_ready returns to 1 the cycle after the plane switch.
4. Second scalar 7 presented exactly on the last-beat transfer with pending empty -> bypass. Beat 197 is 7, no bubble, in_ready stays 1.
5. rst pulsed after 50 beats of value 60 with pending 90 held -> next cycle out_valid=0 and in_ready=1. A new scalar 30 then yields a full clean plane of 196x30 starting at x=y=0.
6. COORD_EN build, scalar 1 -> beats 1..196 show (x,y) from (0,0) through (13,0), (0,1), ..., (13,13).

Source files
------------

// File: rtl/global_unpool_unit_pkg.sv
// global_unpool_unit_pkg: shared constants, FSM state type and width helper for the unpool block
package global_unpool_unit_pkg;
  localparam int PIX_W = 8;
  localparam int DEF_IMG_W = 14;
  localparam int DEF_IMG_H = 14;
  localparam int DEF_TOTAL_PIXELS = DEF_IMG_W * DEF_IMG_H;
  typedef enum logic {IDLE, EMIT} state_t;
  // Counter width that stays at least one bit for degenerate 1-pixel dimensions
  function automatic int cw(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/global_unpool_unit_raster_xy_counter.sv
// raster_xy_counter: raster x/y wrap counter
//   clk, rst   : clock, synchronous active-high reset
//   clear      : force both coordinates to zero (wins over advance)
//   advance    : step one pixel in raster order, wrapping at the plane end
//   x, y, last : current coordinate and final-pixel flag
module raster_xy_counter
  import global_unpool_unit_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  localparam int XW = cw(IMG_W),
  localparam int YW = cw(IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          advance,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last
);
  logic x_end, y_end;
  assign x_end = x == XW'(IMG_W - 1);
  assign y_end = y == YW'(IMG_H - 1);
  assign last  = x_end && y_end;
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      x <= x_end ? '0 : x + 1'b1;
      if (x_end) y <= y_end ? '0 : y + 1'b1;
    end
  end
endmodule

// File: rtl/global_unpool_unit.sv
// global_unpool_unit: broadcasts each accepted 8-bit scalar as an IMG_W x IMG_H raster pixel stream
//   clk, rst                       : clock, synchronous active-high reset
//   in_data/in_valid/in_ready      : scalar input handshake (one active + one pending slot)
//   out_data/out_valid/out_ready   : pixel output handshake
//   out_last                       : final pixel of the plane
//   out_x/out_y                    : beat coordinate, only when GLOBAL_UNPOOL_COORD_EN is defined
module global_unpool_unit
  import global_unpool_unit_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  localparam int XW = cw(IMG_W),
  localparam int YW = cw(IMG_H)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [PIX_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef GLOBAL_UNPOOL_COORD_EN
  output logic [XW-1:0]    out_x,
  output logic [YW-1:0]    out_y,
`endif
  output logic             out_last
);
  state_t state, nxt_state;
  logic [PIX_W-1:0] active, pending, nxt_active, nxt_pending;
  logic pending_full, nxt_full, clear, last, in_fire, out_fire;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  assign in_ready  = !pending_full;
  assign out_valid = state == EMIT;
  assign out_data  = active;
  assign out_last  = out_valid && last;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
`ifdef GLOBAL_UNPOOL_COORD_EN
  assign out_x = x;
  assign out_y = y;
`endif
  // The counter wraps to (0,0) by itself on the last beat, so clear is only needed on plane start from IDLE
  raster_xy_counter #(.IMG_W(IMG_W), .IMG_H(IMG_H)) u_xy (
    .clk(clk), .rst(rst), .clear(clear), .advance(out_fire), .x(x), .y(y), .last(last)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      active <= '0;
      pending <= '0;
      pending_full <= 1'b0;
    end else begin
      state <= nxt_state;
      active <= nxt_active;
      pending <= nxt_pending;
      pending_full <= nxt_full;
    end
  end
  // Last beat: promote pending, else bypass a simultaneous input, else fall back to IDLE
  always_comb begin
    nxt_state = state;
    nxt_active = active;
    nxt_pending = pending;
    nxt_full = pending_full;
    clear = 1'b0;
    if (state == IDLE) begin
      if (in_fire) begin
        nxt_state = EMIT;
        nxt_active = in_data;
        clear = 1'b1;
      end
    end else if (out_fire && last) begin
      if (pending_full) begin
        nxt_active = pending;
        nxt_full = 1'b0;
      end else if (in_fire) nxt_active = in_data;
      else nxt_state = IDLE;
    end else if (in_fire) begin
      nxt_pending = in_data;
      nxt_full = 1'b1;
    end
  end
endmodule
